// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int unsigned LINES_DEFAULT = 16;
  localparam int unsigned WORD_ADDR_W   = 30;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_RD_MISS = 3'd2,
    ST_WR_MEM  = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  function automatic int unsigned tag_width(input int unsigned index_w);
    return WORD_ADDR_W - index_w;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays: combinational read, one fill/update write port, one valid-clear port.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int unsigned LINES   = LINES_DEFAULT,
  parameter int unsigned INDEX_W = $clog2(LINES),
  parameter int unsigned TAG_W   = tag_width(INDEX_W)
) (
  input  logic               clk,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [31:0]        rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [31:0]        wr_data,
  input  logic               clr_en,
  input  logic [INDEX_W-1:0] clr_index
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  // No reset here: valid bits are cleared by the sweep, tag/data are don't-care until filled.
  always_ff @(posedge clk) begin
    if (clr_en) valid_q[clr_index] <= 1'b0;
    if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
      tag_q[wr_index]   <= wr_tag;
      data_q[wr_index]  <= wr_data;
    end
  end

  always_comb begin
    rd_valid = valid_q[rd_index];
    rd_tag   = tag_q[rd_index];
    rd_data  = data_q[rd_index];
  end

endmodule

// File: rtl/dcache_core.sv
// Direct-mapped one-word-line write-through D-cache with invalidate sweep and flush.
module dcache_core
  import dcache_pkg::*;
#(
  parameter int unsigned LINES   = LINES_DEFAULT,
  parameter int unsigned INDEX_W = $clog2(LINES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_flush,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        read_mem,
  output logic        write_mem,
  output logic [31:0] addr,
  output logic        addr_valid,
  output logic        write_data_valid,
  output logic [31:0] write_data,
  output logic        cache_rst_done,
  input  logic        mem_done,
  input  logic [31:0] result
);

  localparam int unsigned TAG_W = tag_width(INDEX_W);

  state_t             state_q, state_d;
  logic [INDEX_W-1:0] sweep_idx_q;
  logic               flush_pend_q;
  logic               rst_done_q;
  logic [29:0]        req_addr_q;
  logic [31:0]        req_wdata_q;
  logic               req_we_q;
  logic [31:0]        resp_data_q;

  logic [29:0]        lookup_addr;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               line_valid, hit, flush_req, sweep_last;
  logic [TAG_W-1:0]   line_tag;
  logic [31:0]        line_data;
  logic               wr_en, clr_en;
  logic [31:0]        wr_data;
  logic               unused_addr_lsb;

  assign unused_addr_lsb = ^cpu_addr[1:0];

  // IDLE looks up the live CPU address; in-flight states use the latched request.
  assign lookup_addr = (state_q == ST_IDLE) ? cpu_addr[31:2] : req_addr_q;
  assign idx         = lookup_addr[INDEX_W-1:0];
  assign tag         = lookup_addr[29:INDEX_W];
  assign hit         = line_valid && (line_tag == tag);
  assign flush_req   = cpu_flush || flush_pend_q;
  assign sweep_last  = (sweep_idx_q == INDEX_W'(LINES - 1));

  dcache_line_store #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_store (
    .clk       (clk),
    .rd_index  (idx),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .wr_en     (wr_en),
    .wr_index  (idx),
    .wr_tag    (tag),
    .wr_data   (wr_data),
    .clr_en    (clr_en),
    .clr_index (sweep_idx_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:    if (sweep_last) state_d = ST_IDLE;
      ST_IDLE: begin
        if (flush_req)    state_d = ST_INIT;
        else if (cpu_req) begin
          if (cpu_we)     state_d = ST_WR_MEM;
          else if (!hit)  state_d = ST_RD_MISS;
        end
      end
      ST_RD_MISS: if (mem_done) state_d = ST_RESP;
      ST_WR_MEM:  if (mem_done) state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_INIT;
    endcase
  end

  always_comb begin
    cpu_ready        = 1'b0;
    cpu_rdata        = '0;
    read_mem         = (state_q == ST_RD_MISS);
    write_mem        = (state_q == ST_WR_MEM);
    addr_valid       = read_mem || write_mem;
    write_data_valid = write_mem;
    addr             = addr_valid ? {req_addr_q, 2'b00} : '0;
    write_data       = write_mem ? req_wdata_q : '0;
    clr_en           = (state_q == ST_INIT);
    wr_en            = 1'b0;
    wr_data          = req_wdata_q;
    unique case (state_q)
      ST_IDLE: if (cpu_req && !flush_req && !cpu_we && hit) begin
        cpu_ready = 1'b1;
        cpu_rdata = line_data;
      end
      ST_RD_MISS: begin
        wr_en   = mem_done;
        wr_data = result;
      end
      ST_WR_MEM: wr_en = mem_done && hit;
      ST_RESP: begin
        cpu_ready = 1'b1;
        cpu_rdata = req_we_q ? '0 : resp_data_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_idx_q  <= '0;
      flush_pend_q <= 1'b0;
      rst_done_q   <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_we_q     <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      if (state_q == ST_INIT) begin
        sweep_idx_q <= sweep_idx_q + 1'b1;
        if (sweep_last) rst_done_q <= 1'b1;
      end
      // A flush seen mid-transaction is held and consumed on the next IDLE cycle.
      if (state_q == ST_IDLE) begin
        flush_pend_q <= 1'b0;
        if (flush_req) rst_done_q <= 1'b0;
        else if (cpu_req) begin
          req_addr_q  <= cpu_addr[31:2];
          req_wdata_q <= cpu_wdata;
          req_we_q    <= cpu_we;
        end
      end else if (state_q != ST_INIT && cpu_flush) begin
        flush_pend_q <= 1'b1;
      end
      if (state_q == ST_RD_MISS && mem_done) resp_data_q <= result;
    end
  end

  assign cache_rst_done = rst_done_q;

endmodule

// File: tb/tb_dcache_core.sv
// Directed self-checking bench for dcache_core.
module tb_dcache_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_flush;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        read_mem, write_mem, addr_valid, write_data_valid;
  logic [31:0] addr, write_data;
  logic        cache_rst_done;
  logic        mem_done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  int both_hi = 0;
  int qual_bad = 0;

  always #5 clk = ~clk;

  dcache_core dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cpu_req          (cpu_req),
    .cpu_we           (cpu_we),
    .cpu_addr         (cpu_addr),
    .cpu_wdata        (cpu_wdata),
    .cpu_flush        (cpu_flush),
    .cpu_rdata        (cpu_rdata),
    .cpu_ready        (cpu_ready),
    .read_mem         (read_mem),
    .write_mem        (write_mem),
    .addr             (addr),
    .addr_valid       (addr_valid),
    .write_data_valid (write_data_valid),
    .write_data       (write_data),
    .cache_rst_done   (cache_rst_done),
    .mem_done         (mem_done),
    .result           (result)
  );

  // Drives one CPU access and plays the memory controller: mem_done after `delay` command cycles.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] res, input int delay, input int flush_at,
                        output logic [31:0] rdata, output int rd_n, output int wr_n,
                        output logic [31:0] addr_seen, output logic [31:0] wdata_seen,
                        output int lat);
    int  mem_n;
    bit  done;
    rd_n = 0; wr_n = 0; mem_n = 0; lat = -1; done = 0;
    rdata = '0; addr_seen = '0; wdata_seen = '0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      mem_done  = 1'b0;
      cpu_flush = (cyc == flush_at);
      #2;
      if (read_mem && write_mem) both_hi++;
      if (addr_valid !== (read_mem | write_mem) || write_data_valid !== write_mem) qual_bad++;
      if (read_mem) rd_n++;
      if (write_mem) begin wr_n++; wdata_seen = write_data; end
      if (read_mem || write_mem) begin
        addr_seen = addr;
        mem_n++;
        if (mem_n == delay) begin mem_done = 1'b1; result = res; end
      end
      if (cpu_ready) begin rdata = cpu_rdata; lat = cyc; done = 1; end
    end
    cpu_req = 1'b0; cpu_flush = 1'b0; mem_done = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL access_timeout addr=%h: cpu_ready never seen within 200 cycles", a);
    end
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b0; cpu_req = 0; cpu_we = 0; cpu_flush = 0; cpu_addr = '0; cpu_wdata = '0;
    mem_done = 0; result = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cache_rst_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", cache_rst_done); end
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", cpu_ready); end
    checks++; if ({read_mem, write_mem, addr_valid} !== 3'b000) begin errors++; $display("FAIL reset_cmds: got %b exp 000", {read_mem, write_mem, addr_valid}); end
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1; n++;
      if (cpu_ready !== 1'b0) begin checks++; errors++; $display("FAIL sweep_ready: got %b exp 0 at cycle %0d", cpu_ready, n); end
      if (cache_rst_done) break;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL sweep_len: got %0d exp 16", n); end
  endtask

  task automatic test_load_miss_hit;
    logic [31:0] rd, as, ws; int r, w, l;
    access(1'b0, 32'h40, '0, 32'hDEAD_BEEF, 5, -1, rd, r, w, as, ws, l);
    checks++; if (r !== 5) begin errors++; $display("FAIL miss_rd_cycles: got %0d exp 5", r); end
    checks++; if (as !== 32'h40) begin errors++; $display("FAIL miss_addr: got %h exp 00000040", as); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL miss_rdata: got %h exp deadbeef", rd); end
    access(1'b0, 32'h43, '0, 32'h0, 1, -1, rd, r, w, as, ws, l);
    checks++; if (l !== 0 || r !== 0) begin errors++; $display("FAIL hit_zero_wait: got lat=%0d rd=%0d exp 0/0", l, r); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hit_rdata: got %h exp deadbeef", rd); end
  endtask

  task automatic test_store_hit;
    logic [31:0] rd, as, ws; int r, w, l;
    access(1'b1, 32'h40, 32'hCAFE_0001, 32'h0, 3, -1, rd, r, w, as, ws, l);
    checks++; if (w !== 3 || r !== 0) begin errors++; $display("FAIL store_cycles: got wr=%0d rd=%0d exp 3/0", w, r); end
    checks++; if (ws !== 32'hCAFE_0001) begin errors++; $display("FAIL store_wdata: got %h exp cafe0001", ws); end
    checks++; if (as !== 32'h40) begin errors++; $display("FAIL store_addr: got %h exp 00000040", as); end
    access(1'b0, 32'h40, '0, 32'h0, 1, -1, rd, r, w, as, ws, l);
    checks++; if (l !== 0 || rd !== 32'hCAFE_0001) begin errors++; $display("FAIL store_hit_update: got lat=%0d %h exp 0 cafe0001", l, rd); end
  endtask

  task automatic test_store_miss;
    logic [31:0] rd, as, ws; int r, w, l;
    access(1'b1, 32'h80, 32'h1234_5678, 32'h0, 2, -1, rd, r, w, as, ws, l);
    checks++; if (w !== 2 || as !== 32'h80) begin errors++; $display("FAIL store_miss_wt: got wr=%0d addr=%h exp 2 00000080", w, as); end
    access(1'b0, 32'h40, '0, 32'h0, 1, -1, rd, r, w, as, ws, l);
    checks++; if (l !== 0 || rd !== 32'hCAFE_0001) begin errors++; $display("FAIL store_miss_noalloc: got lat=%0d %h exp 0 cafe0001", l, rd); end
    access(1'b0, 32'h80, '0, 32'h0BAD_F00D, 1, -1, rd, r, w, as, ws, l);
    checks++; if (r !== 1 || rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL load_after_store_miss: got rd=%0d %h exp 1 0badf00d", r, rd); end
  endtask

  task automatic test_alias;
    logic [31:0] rd, as, ws; int r, w, l;
    access(1'b0, 32'h40, '0, 32'hAAAA_0040, 2, -1, rd, r, w, as, ws, l);
    checks++; if (r !== 2 || rd !== 32'hAAAA_0040) begin errors++; $display("FAIL alias_fill40: got rd=%0d %h exp 2 aaaa0040", r, rd); end
    access(1'b0, 32'h440, '0, 32'hBBBB_0440, 1, -1, rd, r, w, as, ws, l);
    checks++; if (r !== 1 || as !== 32'h440 || rd !== 32'hBBBB_0440) begin errors++; $display("FAIL alias_fill440: got rd=%0d addr=%h %h exp 1 00000440 bbbb0440", r, as, rd); end
    access(1'b0, 32'h440, '0, 32'h0, 1, -1, rd, r, w, as, ws, l);
    checks++; if (l !== 0 || rd !== 32'hBBBB_0440) begin errors++; $display("FAIL alias_hit440: got lat=%0d %h exp 0 bbbb0440", l, rd); end
    access(1'b0, 32'h40, '0, 32'hCCCC_0040, 1, -1, rd, r, w, as, ws, l);
    checks++; if (r !== 1 || rd !== 32'hCCCC_0040) begin errors++; $display("FAIL alias_evicted40: got rd=%0d %h exp 1 cccc0040", r, rd); end
  endtask

  task automatic test_flush_with_req;
    logic [31:0] rd, as, ws; int r, w, l;
    @(negedge clk);
    cpu_flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    #2;
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL flush_wins: got ready=%b exp 0", cpu_ready); end
    @(negedge clk); cpu_flush = 1'b0; #2;
    checks++; if (cache_rst_done !== 1'b0) begin errors++; $display("FAIL flush_done_clr: got %b exp 0", cache_rst_done); end
    access(1'b0, 32'h40, '0, 32'h7777_0000, 1, -1, rd, r, w, as, ws, l);
    checks++; if (r !== 1 || rd !== 32'h7777_0000) begin errors++; $display("FAIL flush_then_serve: got rd=%0d %h exp 1 77770000", r, rd); end
    checks++; if (l < 17) begin errors++; $display("FAIL flush_sweep_first: got lat=%0d exp >=17", l); end
    checks++; if (cache_rst_done !== 1'b1) begin errors++; $display("FAIL flush_done_set: got %b exp 1", cache_rst_done); end
  endtask

  task automatic test_flush_latched;
    logic [31:0] rd, as, ws; int r, w, l; bit dropped, back;
    access(1'b0, 32'h48, '0, 32'h4848_4848, 4, 2, rd, r, w, as, ws, l);
    checks++; if (r !== 4 || rd !== 32'h4848_4848) begin errors++; $display("FAIL latched_miss: got rd=%0d %h exp 4 48484848", r, rd); end
    dropped = 0; back = 0;
    for (int i = 0; i < 4 && !dropped; i++) begin @(negedge clk); #2; if (!cache_rst_done) dropped = 1; end
    for (int i = 0; i < 40 && dropped && !back; i++) begin @(negedge clk); #2; if (cache_rst_done) back = 1; end
    checks++; if (!dropped || !back) begin errors++; $display("FAIL latched_sweep: got dropped=%b back=%b exp 1/1", dropped, back); end
    access(1'b0, 32'h48, '0, 32'h5050_5050, 1, -1, rd, r, w, as, ws, l);
    checks++; if (r !== 1 || rd !== 32'h5050_5050) begin errors++; $display("FAIL latched_invalidated: got rd=%0d %h exp 1 50505050", r, rd); end
  endtask

  task automatic test_reset_mid_miss;
    logic [31:0] rd, as, ws; int r, w, l, n;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h84;
    @(negedge clk); #2;
    checks++; if (read_mem !== 1'b1) begin errors++; $display("FAIL rstmid_inmiss: got read_mem=%b exp 1", read_mem); end
    rst_n = 1'b0; #1;
    checks++; if ({read_mem, addr_valid, cpu_ready, cache_rst_done} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_async: got %b exp 0000", {read_mem, addr_valid, cpu_ready, cache_rst_done});
    end
    cpu_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1; n++;
      if (cache_rst_done) break;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL rstmid_sweep: got %0d exp 16", n); end
    access(1'b0, 32'h84, '0, 32'h8484_0000, 1, -1, rd, r, w, as, ws, l);
    checks++; if (r !== 1 || rd !== 32'h8484_0000) begin errors++; $display("FAIL rstmid_reload: got rd=%0d %h exp 1 84840000", r, rd); end
  endtask

  task automatic test_protocol;
    checks++; if (both_hi !== 0) begin errors++; $display("FAIL rd_wr_exclusive: got %0d overlap cycles exp 0", both_hi); end
    checks++; if (qual_bad !== 0) begin errors++; $display("FAIL qualifiers: got %0d bad cycles exp 0", qual_bad); end
  endtask

  initial begin
    test_reset;
    test_load_miss_hit;
    test_store_hit;
    test_store_miss;
    test_alias;
    test_flush_with_req;
    test_flush_latched;
    test_reset_mid_miss;
    test_protocol;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
